serial_adder: RTL and testbench

Bit-serial 8-bit adder: on a start request it captures two operands, adds them one bit per clock (LSB first) through a single full adder and a carry flip-flop, and raises `done` when the 8-bit sum is complete. It is an area-minimal arithmetic unit: one full adder plus shift registers, with a level start/done handshake for a controlling FSM or processor bus wrapper.

---
 rtl/serial_adder_pkg.sv | 26 ++
 rtl/full_adder_bit.sv | 22 ++
 rtl/serial_adder.sv | 116 +++++++++++
 tb/tb_serial_adder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared definitions for the bit-serial adder: FSM state
//               encoding, default operand width and bit-counter sizing.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

    localparam int SA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } sa_state_e;

    // Counter must hold 0..width-1; a 1-bit operand still needs a 1-bit counter.
    function automatic int sa_cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    localparam int SA_CNT_W = sa_cnt_width(SA_WIDTH);

endpackage
`default_nettype wire

// File: rtl/full_adder_bit.sv
`default_nettype none
// ============================================================================
// Module      : full_adder_bit
// Description : 1-bit combinational full adder.
// Ports       : a, b, cin - addend bits and carry in
//               s         - sum bit
//               cout      - carry out (majority of the three inputs)
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial WIDTH-bit adder. On an accepted start the operands
//               are captured and added LSB first, one bit per clock, through a
//               single full adder and a carry flip-flop. The carry-out of the
//               top bit is discarded (result is modulo 2^WIDTH).
// Ports       : clk   - clock, rising edge
//               rst   - synchronous reset, active low
//               a, b  - operands, sampled only when a start is accepted
//               start - level request; a new add needs start low then high
//               c     - result shift register (final sum while done is high)
//               done  - high while the finished result is held
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             start,
    output logic [WIDTH-1:0] c,
    output logic             done
);

    localparam int                c_cnt_w     = sa_cnt_width(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last_step = c_cnt_w'(WIDTH - 1);

    sa_state_e          r_state;
    sa_state_e          w_state_nxt;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_c;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_carry;
    logic               w_sum;
    logic               w_cout;

    full_adder_bit u_fa (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .cin  (r_carry),
        .s    (w_sum),
        .cout (w_cout)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic. DONE only returns to IDLE once start drops,
    // so a held start cannot launch a second addition.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start)                w_state_nxt = ADD;
            ADD:     if (r_cnt == c_last_step) w_state_nxt = DONE;
            DONE:    if (!start)               w_state_nxt = IDLE;
            default:                           w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand capture, bit-serial step, result shift register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_c     <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_c     <= '0;
                        r_cnt   <= '0;
                        r_carry <= 1'b0;
                    end
                end
                ADD: begin
                    // Sum bits enter at the MSB so after WIDTH steps bit 0
                    // of the sum has shifted down to c[0].
                    r_c     <= {w_sum, r_c[WIDTH-1:1]};
                    r_carry <= w_cout;
                    r_a_sh  <= r_a_sh >> 1;
                    r_b_sh  <= r_b_sh >> 1;
                    r_cnt   <= r_cnt + c_cnt_w'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign c    = r_c;
    assign done = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Self-checking bench for serial_adder. Expected sums are
//               pushed to a scoreboard queue when a start is driven and
//               popped when done is observed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             start;
    logic [WIDTH-1:0] c;
    logic             done;

    int               n_vec;
    int               n_fail;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] last_exp;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .start (start),
        .c     (c),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs are driven and outputs sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Launch one addition, wait (bounded) for done, check latency and sum.
    task automatic run_add(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                           input bit hold, input string tag);
        logic [WIDTH-1:0] s;
        int lat;
        s = av + bv;
        a = av;
        b = bv;
        start = 1'b1;
        exp_q.push_back(s);
        tick();                         // E0: start accepted
        if (!hold) start = 1'b0;
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        check({tag, "_latency"}, lat, 8);
        if (exp_q.size() > 0) begin
            last_exp = exp_q.pop_front();
            check({tag, "_sum"}, c, last_exp);
        end
    endtask

    initial begin
        n_vec    = 0;
        n_fail   = 0;
        last_exp = '0;
        rst      = 1'b0;
        start    = 1'b0;
        a        = '0;
        b        = '0;

        // Reset state
        tick();
        tick();
        check("reset_c", c, 8'h00);
        check("reset_done", done, 1'b0);
        rst = 1'b1;
        tick();
        check("idle_done", done, 1'b0);

        // Held start: done stays high until start drops, c retained
        run_add(8'hB7, 8'hB9, 1'b1, "hold");
        check("hold_c_70", c, 8'h70);
        tick();
        tick();
        check("hold_done_stays", done, 1'b1);
        check("hold_c_stays", c, 8'h70);
        start = 1'b0;
        tick();
        check("hold_done_falls", done, 1'b0);
        check("hold_c_retained", c, 8'h70);
        tick();
        check("idle_c_retained", c, 8'h70);

        // Carry cases with one-cycle start pulses
        run_add(8'hFF, 8'h01, 1'b0, "ff_01");
        check("ff_01_zero", c, 8'h00);
        tick();
        check("ff_01_pulse", done, 1'b0);
        run_add(8'h0F, 8'h01, 1'b0, "0f_01");
        tick();
        check("0f_01_pulse", done, 1'b0);
        check("0f_01_keep", c, last_exp);
        run_add(8'h55, 8'hAA, 1'b0, "55_aa");
        tick();
        check("55_aa_pulse", done, 1'b0);
        run_add(8'h00, 8'h00, 1'b0, "00_00");
        tick();
        check("00_00_pulse", done, 1'b0);

        // Reset three cycles into an addition
        a = 8'h33;
        b = 8'h44;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("midrst_c", c, 8'h00);
        check("midrst_done", done, 1'b0);
        rst = 1'b1;
        tick();
        check("midrst_idle_c", c, 8'h00);
        run_add(8'h12, 8'h34, 1'b0, "after_rst");
        check("after_rst_46", c, 8'h46);
        tick();

        // Reset from DONE
        run_add(8'h01, 8'h02, 1'b1, "done_rst");
        rst = 1'b0;
        tick();
        check("donerst_c", c, 8'h00);
        check("donerst_done", done, 1'b0);
        rst = 1'b1;
        start = 1'b0;
        tick();

        // Reset and start at the same edge: reset wins, no add begins
        a = 8'h11;
        b = 8'h22;
        start = 1'b1;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        start = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        check("rst_start_done", done, 1'b0);
        check("rst_start_c", c, 8'h00);

        // Operand change and start re-pulse during ADD are ignored
        a = 8'h10;
        b = 8'h23;
        start = 1'b1;
        exp_q.push_back(8'h33);
        tick();                         // E0
        start = 1'b0;
        tick();                         // E1
        tick();                         // E2
        a = 8'hFF;
        b = 8'h00;
        start = 1'b1;
        tick();                         // E3: start ignored in ADD
        start = 1'b0;
        begin
            int lat;
            lat = 0;
            for (int k = 4; k <= 12; k++) begin
                tick();
                if (done === 1'b1) begin
                    lat = k;
                    break;
                end
            end
            check("opchg_latency", lat, 8);
            last_exp = exp_q.pop_front();
            check("opchg_sum", c, last_exp);
        end
        tick();
        check("opchg_pulse", done, 1'b0);
        for (int k = 0; k < 10; k++) tick();
        check("opchg_no_extra", done, 1'b0);
        check("opchg_c_kept", c, 8'h33);

        // Back-to-back: second add starts only after start is seen low
        run_add(8'h21, 8'h42, 1'b1, "b2b_first");
        tick();
        tick();
        check("b2b_still_done", done, 1'b1);
        check("b2b_c_63", c, 8'h63);
        start = 1'b0;
        tick();
        check("b2b_low_cycle", done, 1'b0);
        run_add(8'h80, 8'h80, 1'b0, "b2b_second");
        tick();
        check("b2b_second_pulse", done, 1'b0);

        check("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
